// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control FSM: sequences each instruction and decodes Op/Funct into ALU and datapath controls.
// Build option: define MIPS_CTRL_ADDI_EN to enable the addi path (ADDIEX/ADDIWB states).
module mips_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       zero,
   output logic [2:0] ALUcontrol,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic [1:0] PCSrc,
   output logic       PCWrite,
   output logic       Branch,
   output logic       PCEn,
   output logic [3:0] state
);

   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] DECODE  = 4'd1;
   localparam logic [3:0] MEMADR  = 4'd2;
   localparam logic [3:0] MEMRD   = 4'd3;
   localparam logic [3:0] MEMWB   = 4'd4;
   localparam logic [3:0] MEMWR   = 4'd5;
   localparam logic [3:0] EXECUTE = 4'd6;
   localparam logic [3:0] ALUWB   = 4'd7;
   localparam logic [3:0] BRANCH  = 4'd8;
   localparam logic [3:0] ADDIEX  = 4'd9;
   localparam logic [3:0] ADDIWB  = 4'd10;
   localparam logic [3:0] JUMP    = 4'd11;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0] state_d;
   logic       irwrite_s, pcwrite_s, branch_s, memwrite_s, regwrite_s;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_d;
   end

   always_comb begin
      state_d = FETCH;
      case (state)
         FETCH:   state_d = DECODE;
         DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_CTRL_ADDI_EN
               OP_ADDI:      state_d = ADDIEX;
`endif
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (Op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = MEMWB;
         EXECUTE: state_d = ALUWB;
`ifdef MIPS_CTRL_ADDI_EN
         ADDIEX:  state_d = ADDIWB;
`endif
         default: state_d = FETCH;
      endcase
   end

   // Moore decode; write enables are raw here and gated by reset below.
   always_comb begin
      ALUcontrol = 3'b010;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      IorD       = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      PCSrc      = 2'b00;
      irwrite_s  = 1'b0;
      pcwrite_s  = 1'b0;
      branch_s   = 1'b0;
      memwrite_s = 1'b0;
      regwrite_s = 1'b0;
      case (state)
         FETCH: begin
            irwrite_s = 1'b1;
            pcwrite_s = 1'b1;
            ALUSrcB   = 2'b01;
         end
         DECODE:  ALUSrcB = 2'b11;
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD:   IorD = 1'b1;
         MEMWB: begin
            MemtoReg   = 1'b1;
            regwrite_s = 1'b1;
         end
         MEMWR: begin
            IorD       = 1'b1;
            memwrite_s = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            case (Funct)
               6'b100010: ALUcontrol = 3'b110;
               6'b100100: ALUcontrol = 3'b000;
               6'b100101: ALUcontrol = 3'b001;
               6'b101010: ALUcontrol = 3'b111;
               default:   ALUcontrol = 3'b010;
            endcase
         end
         ALUWB: begin
            RegDst     = 1'b1;
            regwrite_s = 1'b1;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUcontrol = 3'b110;
            PCSrc      = 2'b01;
            branch_s   = 1'b1;
         end
`ifdef MIPS_CTRL_ADDI_EN
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDIWB:  regwrite_s = 1'b1;
`endif
         JUMP: begin
            PCSrc     = 2'b10;
            pcwrite_s = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset suppresses every write immediately, before the state register has returned to FETCH.
   assign IRWrite  = irwrite_s  & ~reset;
   assign PCWrite  = pcwrite_s  & ~reset;
   assign Branch   = branch_s   & ~reset;
   assign MemWrite = memwrite_s & ~reset;
   assign RegWrite = regwrite_s & ~reset;
   assign PCEn     = PCWrite | (Branch & zero);

endmodule

// File: tb/tb_mips_control_fsm.sv
// Randomized bench for mips_control_fsm: per-opcode expected state sequences and a per-state output table.
module tb_mips_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op, Funct;
   logic       zero;
   logic [2:0] ALUcontrol;
   logic       ALUSrcA, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCWrite, Branch, PCEn;
   logic [1:0] ALUSrcB, PCSrc;
   logic [3:0] state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   mips_control_fsm dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .zero(zero),
      .ALUcontrol(ALUcontrol), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch),
      .PCEn(PCEn), .state(state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [16:0] observed();
      return {ALUcontrol, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
              RegWrite, PCSrc, PCWrite, Branch, PCEn};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Output table indexed by state number, written straight from the state descriptions.
   function automatic logic [16:0] exp_out(input int st, input logic [5:0] f, input logic z, input logic rst);
      logic [2:0] ac = 3'b010;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic sa = 0, iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, pw = 0, br = 0;
      case (st)
         0:  begin irw = 1; pw = 1; sb = 2'b01; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  iord = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin iord = 1; mw = 1; end
         6:  begin sa = 1; ac = alu_of(f); end
         7:  begin rd = 1; rw = 1; end
         8:  begin sa = 1; ac = 3'b110; ps = 2'b01; br = 1; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin ps = 2'b10; pw = 1; end
         default: ;
      endcase
      if (rst) begin irw = 0; pw = 0; br = 0; mw = 0; rw = 0; end
      return {ac, sa, sb, iord, mw, irw, rd, m2r, rw, ps, pw, br, pw | (br & z)};
   endfunction

   task automatic load_seq(input logic [5:0] op);
      case (op)
         6'b100011: exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
         6'b101011: exp_q = '{4'd0, 4'd1, 4'd2, 4'd5};
         6'b000000: exp_q = '{4'd0, 4'd1, 4'd6, 4'd7};
         6'b000100: exp_q = '{4'd0, 4'd1, 4'd8};
         6'b000010: exp_q = '{4'd0, 4'd1, 4'd11};
`ifdef MIPS_CTRL_ADDI_EN
         6'b001000: exp_q = '{4'd0, 4'd1, 4'd9, 4'd10};
`endif
         default:   exp_q = '{4'd0, 4'd1};
      endcase
   endtask

   // Drives one instruction; abort_at >= 0 asserts reset for two cycles starting at that step.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int abort_at);
      logic [3:0] cur;
      int idx = 0;
      load_seq(op);
      while (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         @(negedge clk);
         Op    = op;
         Funct = funct;
         zero  = 1'($urandom_range(0, 1));
         reset = (idx == abort_at);
         #1;
         check("state", 32'(state), 32'(cur));
         check("outputs", 32'(observed()), 32'(exp_out(int'(cur), funct, zero, reset)));
         if (reset) begin
            exp_q.delete();
            @(negedge clk);
            zero = 1'($urandom_range(0, 1));
            #1;
            check("reset_state", 32'(state), 32'd0);
            check("reset_outputs", 32'(observed()), 32'(exp_out(0, funct, zero, 1'b1)));
         end
         idx++;
      end
   endtask

   logic [5:0] op_tbl[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b111111, 6'b000000};
   logic [5:0] fn_tbl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   initial begin
      reset = 1'b1;
      Op    = 6'd0;
      Funct = 6'd0;
      zero  = 1'b1;
      @(negedge clk);
      #1;
      check("pre_reset_writes", 32'({IRWrite, PCWrite, Branch, PCEn, MemWrite, RegWrite}), 32'd0);
      @(negedge clk);
      #1;
      check("reset_state", 32'(state), 32'd0);
      check("reset_outputs", 32'(observed()), 32'(exp_out(0, 6'd0, zero, 1'b1)));

      // Directed pass over every instruction class and every R-type function.
      run_instr(6'b100011, 6'd0, -1);
      for (int i = 0; i < 5; i++) run_instr(6'b000000, fn_tbl[i], -1);
      run_instr(6'b000000, 6'b111111, -1);
      for (int i = 0; i < 4; i++) run_instr(6'b000100, 6'd0, -1);
      run_instr(6'b101011, 6'd0, -1);
      run_instr(6'b000010, 6'd0, -1);
      run_instr(6'b111111, 6'd0, -1);
      run_instr(6'b001000, 6'd0, -1);
      run_instr(6'b100011, 6'd0, 3);

      // Randomized mix with occasional mid-instruction resets.
      for (int i = 0; i < 120; i++) begin
         logic [5:0] op, fn;
         int abort_at;
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : op_tbl[$urandom_range(0, 7)];
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fn_tbl[$urandom_range(0, 4)];
         abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(op, fn, abort_at);
      end

      @(negedge clk);
      reset = 1'b0;
      #1;
      check("final_state", 32'(state), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multicycle MIPS control unit that sits directly upstream of the ALU. It sequences each instruction through fetch, decode, execute, memory and writeback states. It decodes Op and Funct into the 3-bit ALUcontrol code the ALU consumes, and it consumes the ALU's zero flag to resolve beq. All datapath enables and mux selects are Moore outputs of the state register, except PCEn, which also depends on zero.

## Interface
- No parameters; state encoding is fixed (below).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Op  in  6  instruction opcode from instruction register, stable from DECODE onward
- Funct  in  6  R-type function field
- zero  in  1  ALU zero flag
- ALUcontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register write enable
- RegDst  out  1  destination: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = memory data
- RegWrite  out  1  register file write enable
- PCSrc  out  2  00 ALUresult, 01 ALUOut, 10 jump target
- PCWrite  out  1  unconditional PC write
- Branch  out  1  conditional-branch qualifier
- PCEn  out  1  PCWrite | (Branch & zero), combinational
- state  out  4  current state, for verification

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 are illegal and go to FETCH on the next edge.
- Outputs not listed for a state are 0. ALUcontrol defaults to 010.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, add. Next state: DECODE.
- DECODE: ALUSrcB=11, add. Next state by Op:
  - 100011 or 101011 → MEMADR
  - 000000 → EXECUTE
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other Op → FETCH (instruction ignored)
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state: MEMRD if Op=100011, else MEMWR.
- MEMRD: IorD=1. Next state: MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1. Next state: FETCH.
- MEMWR: IorD=1, MemWrite=1. Next state: FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUcontrol from Funct:
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - other Funct → 010
  - Next state: ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next state: FETCH.
- BRANCH: ALUSrcA=1, sub, PCSrc=01, Branch=1. Next state: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Next state: ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state: FETCH.

## Timing
- Instruction latency, counted from FETCH through the last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Outputs change only after a clock edge, with one exception: PCEn follows zero combinationally during BRANCH.
- Reset:
  - State becomes FETCH (0) on the first rising edge with reset=1.
  - While reset=1, IRWrite, PCWrite, Branch, PCEn, MemWrite and RegWrite are forced to 0 combinationally, including in the cycle before that edge.
  - All other outputs decode normally from the current state.
- After reset deasserts, the FETCH outputs apply: IRWrite=1, PCWrite=1, PCEn=1, ALUSrcB=01, ALUcontrol=010.
- Reset mid-instruction abandons the instruction. No partial write is issued during the reset cycle.
- Op and Funct are ignored in FETCH. In DECODE, MEMADR and EXECUTE they are sampled combinationally each cycle.

## Configuration
- MIPS_CTRL_ADDI_EN defined: ADDIEX and ADDIWB exist as specified.
- MIPS_CTRL_ADDI_EN undefined: Op=001000 is treated as an unknown opcode (DECODE → FETCH). Encodings 9 and 10 are unreachable and treated as illegal (→ FETCH).

## Test plan
- Reset: hold reset=1 for 2 cycles from a random state, then release → state=0; all write enables 0 during reset; IRWrite=1 and PCEn=1 on the first cycle after release.
- lw (Op=100011) → state sequence 0,1,2,3,4,0. MEMWB has RegWrite=1 and MemtoReg=1. MemWrite stays 0 throughout.
- R-type (Op=0) with Funct 100000, 100010, 100100, 100101, 101010 → EXECUTE ALUcontrol is 010, 110, 000, 001, 111 respectively. ALUWB has RegDst=1 and RegWrite=1.
- beq (Op=000100) → BRANCH ALUcontrol=110; PCEn=1 with zero=1, PCEn=0 with zero=0; returns to FETCH after 3 cycles.
- sw, j and illegal Op 111111:
  - sw → sequence 0,1,2,5,0 with MemWrite=1 only in state 5.
  - j → sequence 0,1,11,0 with PCSrc=10.
  - Op 111111 → sequence 0,1,0 with no writes.
- addi (Op=001000) → with the macro defined, sequence 0,1,9,10,0 with RegWrite=1 in state 10; with the macro undefined, sequence 0,1,0.
